// File: rtl/programmable_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
// Each channel counts system clocks up to its active divisor and produces a
// square wave (toggle mode) or a one-cycle pulse (pulse mode) plus a wrap
// strobe. New divisor/mode values land in a shadow register and are promoted
// to the active set at the next wrap, immediately when the channel is
// stopped, or on a global sync, so a running period is never truncated.
// All outputs are registered signals in the CLK domain, not derived clocks.

module programmable_clock_divider #(
    parameter  int CHANNELS    = 2,
    parameter  int WIDTH       = 16,
    parameter  int DEFAULT_DIV = 0,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic                cfg_ack,
    output logic [CHANNELS-1:0] division_CLK,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    // Channel select widened once so range and address compares are clean.
    logic [31:0] ch_ext;
    logic        ch_valid;

    assign ch_ext   = 32'(cfg_ch);
    assign ch_valid = (ch_ext < 32'(CHANNELS));

    // Acknowledge a write one cycle after it is accepted; out-of-range writes stay silent.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_wr && ch_valid;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel

        logic [WIDTH-1:0] count_q,  count_d;
        logic [WIDTH-1:0] div_a_q,  div_a_d;
        logic             mode_a_q, mode_a_d;
        logic [WIDTH-1:0] div_s_q,  div_s_d;
        logic             mode_s_q, mode_s_d;
        logic             pend_q,   pend_d;
        logic             out_q,    out_d;
        logic             tick_q,   tick_d;
        logic             wr_hit;
        logic             wrap;

        assign wr_hit = cfg_wr && ch_valid && (ch_ext == 32'(g));

        // A stopped channel may have been given a divisor below its frozen
        // count, so wrapping on reaching-or-passing keeps count bounded by div_a.
        assign wrap = (count_q >= div_a_q);

        // Next-state: sync restarts, enabled channels count/wrap, stopped channels hold.
        always_comb begin
            count_d  = count_q;
            div_a_d  = div_a_q;
            mode_a_d = mode_a_q;
            div_s_d  = div_s_q;
            mode_s_d = mode_s_q;
            pend_d   = pend_q;
            out_d    = out_q;
            tick_d   = 1'b0;

            if (sync) begin
                count_d = '0;
                out_d   = 1'b0;
                if (pend_q) begin
                    div_a_d  = div_s_q;
                    mode_a_d = mode_s_q;
                    pend_d   = 1'b0;
                end
            end else if (en[g]) begin
                if (wrap) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    out_d   = mode_a_q ? 1'b1 : ~out_q;
                    if (pend_q) begin
                        div_a_d  = div_s_q;
                        mode_a_d = mode_s_q;
                        pend_d   = 1'b0;
                        if (mode_s_q != mode_a_q) begin
                            out_d = mode_s_q;
                        end
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                    if (mode_a_q) begin
                        out_d = 1'b0;
                    end
                end
            end else begin
                if (mode_a_q) begin
                    out_d = 1'b0;
                end
                if (pend_q) begin
                    div_a_d  = div_s_q;
                    mode_a_d = mode_s_q;
                    pend_d   = 1'b0;
                end
            end

            // A write always lands in the shadow after any promotion above,
            // so a write coinciding with a load stays pending for later.
            if (wr_hit) begin
                div_s_d  = cfg_div;
                mode_s_d = cfg_mode;
                pend_d   = 1'b1;
            end
        end

        // Channel state register with synchronous reset to the default divisor.
        always_ff @(posedge CLK) begin
            if (RST) begin
                count_q  <= '0;
                div_a_q  <= RESET_DIV;
                mode_a_q <= 1'b0;
                div_s_q  <= RESET_DIV;
                mode_s_q <= 1'b0;
                pend_q   <= 1'b0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                count_q  <= count_d;
                div_a_q  <= div_a_d;
                mode_a_q <= mode_a_d;
                div_s_q  <= div_s_d;
                mode_s_q <= mode_s_d;
                pend_q   <= pend_d;
                out_q    <= out_d;
                tick_q   <= tick_d;
            end
        end

        assign division_CLK[g] = out_q;
        assign tick[g]         = tick_q;
    end

endmodule
